// File: rtl/avg2fifo.sv
// Drains JRT average results into an output FIFO, with a start timeout, a result counter and sticky error flags.
// Optional build macro AVG2FIFO_TAG_EN: writes a tag word {8'hA7, 8'h00, result_count} before every result.
module avg2fifo #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_average_req,
  input  logic        o_average_busy,
  input  logic [31:0] o_average_return,
  input  logic        full,
  output logic [31:0] din,
  output logic        we,
  output logic [15:0] result_count,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        idle
);

`ifdef AVG2FIFO_TAG_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RUN      = 3'd2,
    ST_PUSH_TAG = 3'd3,
    ST_PUSH     = 3'd4
  } state_t;

  function automatic logic [31:0] tag_word(input logic [15:0] cnt);
    return {8'hA7, 8'h00, cnt};
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_PUSH  = 3'd4
  } state_t;
`endif

  localparam logic [15:0] TIMER_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      state_r;
  logic [15:0] timer_r;
  logic [31:0] result_r;
  logic [15:0] count_r;
  logic        err_timeout_r;
  logic        err_overrun_r;
  logic [31:0] din_s;
  logic        we_s;

  // FIFO write port: write enable follows full directly so a stall never drops a word.
  always_comb begin
    we_s  = 1'b0;
    din_s = result_r;
    case (state_r)
      ST_PUSH: begin
        we_s  = !full;
        din_s = result_r;
      end
`ifdef AVG2FIFO_TAG_EN
      ST_PUSH_TAG: begin
        we_s  = !full;
        din_s = tag_word(count_r);
      end
`endif
      default: begin
        we_s  = 1'b0;
        din_s = result_r;
      end
    endcase
  end

  // Handshake sequencer, timeout timer, result latch, counter and sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      timer_r       <= 16'd0;
      result_r      <= 32'd0;
      count_r       <= 16'd0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      // A start outside IDLE is dropped, only flagged.
      if (i_average_req && (state_r != ST_IDLE)) begin
        err_overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (i_average_req) begin
            state_r <= ST_ARMED;
            timer_r <= 16'd0;
          end
        end
        ST_ARMED: begin
          if (o_average_busy) begin
            state_r <= ST_RUN;
          end else if (timer_r == TIMER_LAST) begin
            err_timeout_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        ST_RUN: begin
          if (!o_average_busy) begin
            result_r <= o_average_return;
`ifdef AVG2FIFO_TAG_EN
            state_r  <= ST_PUSH_TAG;
`else
            state_r  <= ST_PUSH;
`endif
          end
        end
`ifdef AVG2FIFO_TAG_EN
        ST_PUSH_TAG: begin
          if (!full) begin
            state_r <= ST_PUSH;
          end
        end
`endif
        ST_PUSH: begin
          if (!full) begin
            count_r <= count_r + 16'd1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign din          = din_s;
  assign we           = we_s;
  assign result_count = count_r;
  assign err_timeout  = err_timeout_r;
  assign err_overrun  = err_overrun_r;
  assign idle         = (state_r == ST_IDLE);

endmodule
